// File: rtl/decode_stage.sv
// RV32I decode stage: decodes each accepted instruction into a control bundle
// and queues it in a small valid/ready FIFO in front of register read.
module decode_stage #(
  parameter int ADDRESS_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int DEPTH            = 2,
  parameter int OP_WIDTH         = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDRESS_SIZE-1:0]     instruction,
  input  logic [ADDRESS_SIZE-1:0]     pc_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDRESS_SIZE-1:0]     pc_out,
  output logic [REG_ADDRESS_SIZE-1:0] addr_r1,
  output logic [REG_ADDRESS_SIZE-1:0] addr_r2,
  output logic [REG_ADDRESS_SIZE-1:0] addr_rd,
  output logic                        register_write,
  output logic [ADDRESS_SIZE-1:0]     immediate,
  output logic                        use_immediate,
  output logic [OP_WIDTH-1:0]         alu_op,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic                        branch,
  output logic                        jump,
  output logic                        illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] OPC_RR    = 7'b0110011;
  localparam logic [6:0] OPC_IR    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0]     pc;
    logic [REG_ADDRESS_SIZE-1:0] r1;
    logic [REG_ADDRESS_SIZE-1:0] r2;
    logic [REG_ADDRESS_SIZE-1:0] rd;
    logic                        reg_write;
    logic [ADDRESS_SIZE-1:0]     imm;
    logic                        use_imm;
    logic [OP_WIDTH-1:0]         alu_op;
    logic                        mem_read;
    logic                        mem_write;
    logic                        branch;
    logic                        jump;
    logic                        illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [ADDRESS_SIZE-1:0] imm_i;
  logic [ADDRESS_SIZE-1:0] imm_s;
  logic [ADDRESS_SIZE-1:0] imm_b;
  logic [ADDRESS_SIZE-1:0] imm_u;
  logic [ADDRESS_SIZE-1:0] imm_j;

  entry_t decoded;
  entry_t buffer [DEPTH];
  entry_t head;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic push;
  logic pop;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  // Signed casts sign-extend each raw field to the datapath width.
  assign imm_i = ADDRESS_SIZE'($signed(instruction[31:20]));
  assign imm_s = ADDRESS_SIZE'($signed({instruction[31:25], instruction[11:7]}));
  assign imm_b = ADDRESS_SIZE'($signed({instruction[31], instruction[7], instruction[30:25],
                                        instruction[11:8], 1'b0}));
  assign imm_u = ADDRESS_SIZE'($signed({instruction[31:12], 12'b0}));
  assign imm_j = ADDRESS_SIZE'($signed({instruction[31], instruction[19:12], instruction[20],
                                        instruction[30:21], 1'b0}));

  always_comb begin
    decoded    = '0;
    decoded.pc = pc_in;
    decoded.r1 = REG_ADDRESS_SIZE'(instruction[19:15]);
    decoded.r2 = REG_ADDRESS_SIZE'(instruction[24:20]);
    decoded.rd = REG_ADDRESS_SIZE'(instruction[11:7]);
    case (opcode)
      OPC_RR: begin
        decoded.reg_write = 1'b1;
        decoded.alu_op    = OP_WIDTH'({instruction[30], funct3});
      end
      OPC_IR: begin
        decoded.reg_write = 1'b1;
        decoded.use_imm   = 1'b1;
        decoded.imm       = imm_i;
        // Only the shift-right pair uses bit 30 to pick arithmetic vs logical.
        decoded.alu_op    = OP_WIDTH'({(funct3 == 3'b101) & instruction[30], funct3});
      end
      OPC_LOAD: begin
        decoded.reg_write = 1'b1;
        decoded.use_imm   = 1'b1;
        decoded.mem_read  = 1'b1;
        decoded.imm       = imm_i;
      end
      OPC_STORE: begin
        decoded.use_imm   = 1'b1;
        decoded.mem_write = 1'b1;
        decoded.imm       = imm_s;
      end
      OPC_BR: begin
        decoded.branch = 1'b1;
        decoded.imm    = imm_b;
        decoded.alu_op = OP_WIDTH'({1'b0, funct3});
      end
      OPC_LUI, OPC_AUIPC: begin
        decoded.reg_write = 1'b1;
        decoded.use_imm   = 1'b1;
        decoded.imm       = imm_u;
      end
      OPC_JAL: begin
        decoded.reg_write = 1'b1;
        decoded.jump      = 1'b1;
        decoded.use_imm   = 1'b1;
        decoded.imm       = imm_j;
      end
      OPC_JALR: begin
        decoded.reg_write = 1'b1;
        decoded.jump      = 1'b1;
        decoded.use_imm   = 1'b1;
        decoded.imm       = imm_i;
      end
      default: decoded.illegal = 1'b1;
    endcase
    if (instruction[11:7] == 5'd0) decoded.reg_write = 1'b0;
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flush wins over push and pop; a same-cycle incoming instruction is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) buffer[k] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buffer[wr_ptr] <= decoded;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head           = buffer[rd_ptr];
  assign pc_out         = head.pc;
  assign addr_r1        = head.r1;
  assign addr_r2        = head.r2;
  assign addr_rd        = head.rd;
  assign register_write = head.reg_write;
  assign immediate      = head.imm;
  assign use_immediate  = head.use_imm;
  assign alu_op         = head.alu_op;
  assign mem_read       = head.mem_read;
  assign mem_write      = head.mem_write;
  assign branch         = head.branch;
  assign jump           = head.jump;
  assign illegal        = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic compared
// against a queue-based reference of the decode stage.
module tb_decode_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] pc_in = '0;
  logic        in_ready, out_valid;
  logic [31:0] pc_out, immediate;
  logic [4:0]  addr_r1, addr_r2, addr_rd;
  logic        register_write, use_immediate, mem_read, mem_write, branch, jump, illegal;
  logic [3:0]  alu_op;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  r1, r2, rd;
    logic        rw;
    logic [31:0] imm;
    logic        ui;
    logic [3:0]  alu;
    logic        mr, mw, br, jp, ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  decode_stage #(.ADDRESS_SIZE(32), .REG_ADDRESS_SIZE(5), .DEPTH(DEPTH), .OP_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .addr_r1(addr_r1), .addr_r2(addr_r2), .addr_rd(addr_rd),
    .register_write(register_write), .immediate(immediate), .use_immediate(use_immediate),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Immediates computed as signed integers from the field weights.
  function automatic logic [31:0] immI(input logic [31:0] i);
    int v = int'(i[31:20]);
    if (i[31]) v -= 4096;
    return 32'(v);
  endfunction

  function automatic logic [31:0] immS(input logic [31:0] i);
    int v = int'(i[31:25]) * 32 + int'(i[11:7]);
    if (i[31]) v -= 4096;
    return 32'(v);
  endfunction

  function automatic logic [31:0] immB(input logic [31:0] i);
    int v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    if (i[31]) v -= 4096;
    return 32'(v);
  endfunction

  function automatic logic [31:0] immJ(input logic [31:0] i);
    int v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    if (i[31]) v -= 1048576;
    return 32'(v);
  endfunction

  function automatic exp_t refDecode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    e    = '0;
    e.pc = pc;
    e.r1 = i[19:15];
    e.r2 = i[24:20];
    e.rd = i[11:7];
    case (i[6:0])
      7'h33: begin e.rw = 1; e.alu = {i[30], i[14:12]}; end
      7'h13: begin
        e.rw = 1; e.ui = 1; e.imm = immI(i);
        e.alu = {(i[14:12] == 3'b101) && i[30], i[14:12]};
      end
      7'h03: begin e.rw = 1; e.ui = 1; e.mr = 1; e.imm = immI(i); end
      7'h23: begin e.ui = 1; e.mw = 1; e.imm = immS(i); end
      7'h63: begin e.br = 1; e.imm = immB(i); e.alu = {1'b0, i[14:12]}; end
      7'h37, 7'h17: begin e.rw = 1; e.ui = 1; e.imm = i & 32'hFFFF_F000; end
      7'h6F: begin e.rw = 1; e.jp = 1; e.ui = 1; e.imm = immJ(i); end
      7'h67: begin e.rw = 1; e.jp = 1; e.ui = 1; e.imm = immI(i); end
      default: e.ill = 1;
    endcase
    if (i[11:7] == 5'd0) e.rw = 0;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = {pc_out, addr_r1, addr_r2, addr_rd, register_write, immediate, use_immediate,
         alu_op, mem_read, mem_write, branch, jump, illegal};
    return o;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0]  ops [10];
    logic [31:0] w;
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) w[6:0] = ops[k];
    return w;
  endfunction

  task automatic expectEq(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    expectEq({tag, ".out_valid"}, out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) expectEq({tag, ".bundle"}, observed(), exp_q[0]);
  endtask

  // Drives one cycle of inputs, advances the reference queue across the edge, then checks.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic rdy, input logic fl, input string tag);
    bit will_push, will_pop;
    in_valid = v; instruction = ins; pc_in = pc; out_ready = rdy; flush = fl;
    #1;
    expectEq({tag, ".in_ready"}, in_ready, exp_q.size() < DEPTH);
    will_push = v && (exp_q.size() < DEPTH);
    will_pop  = rdy && (exp_q.size() > 0);
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (will_pop) void'(exp_q.pop_front());
      if (will_push) exp_q.push_back(refDecode(ins, pc));
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    $display("[TB] start");
    #12;
    expectEq("reset.out_valid", out_valid, 1'b0);
    expectEq("reset.outputs", observed(), '0);
    expectEq("reset.in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1, 32'h002081B3, 32'h100, 0, 0, "add");
    expectEq("add.r1", addr_r1, 5'd1);
    expectEq("add.r2", addr_r2, 5'd2);
    expectEq("add.rd", addr_rd, 5'd3);
    expectEq("add.rw_alu_ui", {register_write, alu_op, use_immediate}, {1'b1, 4'b0000, 1'b0});

    applyStimulus(1, 32'h402081B3, 32'h104, 1, 0, "sub");
    expectEq("sub.alu", alu_op, 4'b1000);
    applyStimulus(1, 32'hFFC12283, 32'h108, 1, 0, "lw");
    expectEq("lw.mr_imm_rd", {mem_read, immediate, addr_rd}, {1'b1, 32'hFFFF_FFFC, 5'd5});
    applyStimulus(1, 32'h00512423, 32'h10C, 1, 0, "sw");
    expectEq("sw.mw_imm_rw_r2", {mem_write, immediate, register_write, addr_r2},
             {1'b1, 32'h0000_0008, 1'b0, 5'd5});
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "drain");

    applyStimulus(1, 32'h00100093, 32'h200, 0, 0, "bp1");
    applyStimulus(1, 32'h00200113, 32'h204, 0, 0, "bp2");
    expectEq("bp.full_in_ready", in_ready, 1'b0);
    applyStimulus(1, 32'h00300193, 32'h208, 0, 0, "bp3");
    expectEq("bp.head_pc", pc_out, 32'h200);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "rel1");
    expectEq("rel1.pc", pc_out, 32'h204);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "rel2");
    expectEq("rel2.empty", out_valid, 1'b0);

    applyStimulus(1, 32'h00400213, 32'h300, 0, 0, "fl1");
    applyStimulus(1, 32'h00500293, 32'h304, 0, 0, "fl2");
    applyStimulus(1, 32'h00600313, 32'h308, 0, 1, "flush");
    expectEq("flush.out_valid", out_valid, 1'b0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "postflush");
    expectEq("postflush.out_valid", out_valid, 1'b0);

    applyStimulus(1, 32'h00000000, 32'h400, 0, 0, "zero");
    expectEq("zero.ill_rw", {illegal, register_write}, 2'b10);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "zdrain");

    for (int n = 0; n < 400; n++)
      applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, "rand");

    applyStimulus(1, 32'h0080006F, 32'h500, 0, 0, "pre_rst1");
    applyStimulus(1, 32'hFE208EE3, 32'h504, 0, 0, "pre_rst2");
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    expectEq("async_rst.out_valid", out_valid, 1'b0);
    expectEq("async_rst.outputs", observed(), '0);
    @(posedge clk); #1;
    expectEq("async_rst.hold", out_valid, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1, 32'h123450B7, 32'h600, 0, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
